conv_result_packer: RTL and testbench



---
 rtl/conv_pkg.sv | 32 +++
 rtl/conv_result_packer_if.sv | 35 +++
 rtl/conv_word_fifo.sv | 82 ++++++++
 rtl/conv_result_packer.sv | 141 ++++++++++++++
 tb/tb_conv_result_packer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | conv_pkg : shared widths, packer states and the 8-bit clamp helper.    |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
package conv_pkg;

   localparam int OUT_BITS     = 8;
   localparam int PIX_PER_WORD = 4;
   localparam int WORD_BITS    = OUT_BITS * PIX_PER_WORD;
   localparam int LANE_W       = $clog2(PIX_PER_WORD);
   localparam int CONV_BITS    = 9;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      DRAIN   = 2'd1,
      DONE    = 2'd2
   } state_e;

   // Saturate a sign-extended result pixel into the unsigned 0..255 range.
   function automatic logic [OUT_BITS-1:0] clamp_u8(input logic signed [31:0] v);
      if (v < 0) begin
         return '0;
      end else if (v > 32'sd255) begin
         return '1;
      end else begin
         return v[OUT_BITS-1:0];
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/conv_result_packer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | conv_result_packer_if : pixel-in / word-out stream and frame status.   |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
interface conv_result_packer_if
   import conv_pkg::*;
#(
   parameter int BITS       = CONV_BITS,
   parameter int OUT_PIXELS = 9
);
   localparam int CNT_W = $clog2(OUT_PIXELS + 1);

   logic                 clear;
   logic [BITS-1:0]      pix_in;
   logic                 pix_valid;
   logic [WORD_BITS-1:0] word_out;
   logic                 word_valid;
   logic                 word_ready;
   logic                 frame_done;
   logic                 overflow;
   logic [CNT_W-1:0]     pixel_count;

   modport slave (
      input  clear, pix_in, pix_valid, word_ready,
      output word_out, word_valid, frame_done, overflow, pixel_count
   );

   modport master (
      output clear, pix_in, pix_valid, word_ready,
      input  word_out, word_valid, frame_done, overflow, pixel_count
   );

endinterface
`default_nettype wire

// File: rtl/conv_word_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | conv_word_fifo : first-word-fall-through synchronous FIFO.             |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module conv_word_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  wire logic                     clk,
   input  wire logic                     reset,
   input  wire logic                     flush_i,
   input  wire logic                     push_i,
   input  wire logic [WIDTH-1:0]         data_i,
   input  wire logic                     pop_i,
   output logic      [WIDTH-1:0]         data_o,
   output logic                          full_o,
   output logic                          empty_o,
   output logic      [$clog2(DEPTH):0]   level_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q;
   logic [AW-1:0]    wr_q;
   logic [AW:0]      cnt_q;
   logic [AW:0]      cnt_d;
   logic [WIDTH-1:0] hold_q;
   logic             do_push;
   logic             do_pop;
   logic             wipe;

   assign wipe    = reset || flush_i;
   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign level_o = cnt_q;

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wipe) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         hold_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (do_push) begin
            wr_q <= wr_q + 1'b1;
         end
         if (do_pop) begin
            rd_q <= rd_q + 1'b1;
         end
         if (!empty_o) begin
            hold_q <= mem_q[rd_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !wipe) begin
         mem_q[wr_q] <= data_i;
      end
   end

   // While empty the output keeps showing the last word that was at the head.
   assign data_o = empty_o ? hold_q : mem_q[rd_q];

endmodule
`default_nettype wire

// File: rtl/conv_result_packer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | conv_result_packer : clamps result pixels, packs 4 per word, buffers.  |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module conv_result_packer
   import conv_pkg::*;
#(
   parameter int BITS       = CONV_BITS,
   parameter int OUT_PIXELS = 9,
   parameter int SHIFT      = 0,
   parameter int FIFO_DEPTH = 4
) (
   input wire logic             clk,
   input wire logic             reset,
   conv_result_packer_if.slave  bus
);
   localparam int CNT_W   = $clog2(OUT_PIXELS + 1);
   localparam int FIFO_AW = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(OUT_PIXELS - 1);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);
   localparam logic [FIFO_AW:0]  ONE_LEFT  = (FIFO_AW+1)'(1);

   state_e               state_q, state_d;
   logic [LANE_W-1:0]    lane_q;
   logic [WORD_BITS-1:0] pack_q;
   logic [CNT_W-1:0]     count_q;
   logic                 overflow_q;

   logic signed [BITS-1:0] pix_shift;
   logic signed [31:0]     pix_ext;
   logic [OUT_BITS-1:0]    pix_u8;
   logic [WORD_BITS-1:0]   word_asm;
   logic                   accept;
   logic                   last_pix;
   logic                   push;
   logic                   pop;
   logic                   drop;
   logic                   ovf_evt;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [FIFO_AW:0]       fifo_level;
   logic [WORD_BITS-1:0]   fifo_data;

   assign pix_shift = $signed(bus.pix_in) >>> SHIFT;
   assign pix_ext   = {{(32-BITS){pix_shift[BITS-1]}}, pix_shift};
   assign pix_u8    = clamp_u8(pix_ext);

   // Lanes above the current one are still zero in pack_q, so a short final word pads itself.
   for (genvar i = 0; i < PIX_PER_WORD; i++) begin : g_lane
      assign word_asm[i*OUT_BITS +: OUT_BITS] =
         (lane_q == LANE_W'(i)) ? pix_u8 : pack_q[i*OUT_BITS +: OUT_BITS];
   end

   assign accept   = bus.pix_valid && (state_q == COLLECT) && !bus.clear;
   assign last_pix = (count_q == LAST_IDX);
   assign push     = accept && ((lane_q == LAST_LANE) || last_pix);
   assign pop      = !fifo_empty && bus.word_ready && !bus.clear;
   assign drop     = push && fifo_full && !pop;

   always_comb begin
      state_d = state_q;
      ovf_evt = drop;
      case (state_q)
         COLLECT: begin
            if (accept && last_pix) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (bus.pix_valid) begin
               ovf_evt = 1'b1;
            end
            if (fifo_empty || (fifo_level == ONE_LEFT && pop)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.pix_valid) begin
               ovf_evt = 1'b1;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || bus.clear) begin
         state_q <= COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || bus.clear) begin
         lane_q     <= '0;
         pack_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (accept) begin
            count_q <= count_q + 1'b1;
            if (push) begin
               lane_q <= '0;
               pack_q <= '0;
            end else begin
               lane_q <= lane_q + 1'b1;
               pack_q <= word_asm;
            end
         end
         if (ovf_evt) begin
            overflow_q <= 1'b1;
         end
      end
   end

   conv_word_fifo #(
      .WIDTH (WORD_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush_i (bus.clear),
      .push_i  (push),
      .data_i  (word_asm),
      .pop_i   (pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign bus.word_out    = fifo_data;
   assign bus.word_valid  = !fifo_empty;
   assign bus.frame_done  = (state_q == DONE);
   assign bus.overflow    = overflow_q;
   assign bus.pixel_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_result_packer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_conv_result_packer : directed self-checking bench, three configs.   |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_conv_result_packer;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   conv_result_packer_if #(.BITS(9),  .OUT_PIXELS(9))  ifa ();
   conv_result_packer_if #(.BITS(12), .OUT_PIXELS(12)) ifb ();
   conv_result_packer_if #(.BITS(9),  .OUT_PIXELS(1))  ifc ();

   conv_result_packer #(.BITS(9), .OUT_PIXELS(9), .SHIFT(0), .FIFO_DEPTH(4)) u_dut_a (
      .clk   (clk),
      .reset (rst),
      .bus   (ifa)
   );

   conv_result_packer #(.BITS(12), .OUT_PIXELS(12), .SHIFT(0), .FIFO_DEPTH(2)) u_dut_b (
      .clk   (clk),
      .reset (rst),
      .bus   (ifb)
   );

   conv_result_packer #(.BITS(9), .OUT_PIXELS(1), .SHIFT(2), .FIFO_DEPTH(4)) u_dut_c (
      .clk   (clk),
      .reset (rst),
      .bus   (ifc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [8:0] clampv [4];

   initial begin
      clampv = '{9'h1FF, 9'h100, 9'h0FF, 9'h080};
      rst = 1'b1;
      ifa.clear = 1'b0; ifa.pix_in = '0; ifa.pix_valid = 1'b0; ifa.word_ready = 1'b0;
      ifb.clear = 1'b0; ifb.pix_in = '0; ifb.pix_valid = 1'b0; ifb.word_ready = 1'b0;
      ifc.clear = 1'b0; ifc.pix_in = '0; ifc.pix_valid = 1'b0; ifc.word_ready = 1'b0;
      step();
      step();
      chk("rst_a_valid", 32'(ifa.word_valid), 32'd0);
      chk("rst_a_word",  ifa.word_out, 32'h0);
      chk("rst_a_done",  32'(ifa.frame_done), 32'd0);
      chk("rst_a_ovf",   32'(ifa.overflow), 32'd0);
      chk("rst_a_count", 32'(ifa.pixel_count), 32'd0);
      chk("rst_b_valid", 32'(ifb.word_valid), 32'd0);
      chk("rst_c_word",  ifc.word_out, 32'h0);
      rst = 1'b0;

      // A: basic packing of 1..9 with the consumer always ready
      ifa.word_ready = 1'b1;
      ifa.pix_valid  = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         ifa.pix_in = 9'(k);
         step();
         if (k == 3) chk("a_lat_none", 32'(ifa.word_valid), 32'd0);
         if (k == 4) chk("a_w0", ifa.word_out, 32'h04030201);
         if (k == 4) chk("a_w0_valid", 32'(ifa.word_valid), 32'd1);
         if (k == 5) chk("a_w0_popped", 32'(ifa.word_valid), 32'd0);
         if (k == 8) chk("a_w1", ifa.word_out, 32'h08070605);
         if (k == 9) chk("a_w2", ifa.word_out, 32'h00000009);
         if (k == 9) chk("a_w2_valid", 32'(ifa.word_valid), 32'd1);
      end
      ifa.pix_valid = 1'b0;
      chk("a_count9", 32'(ifa.pixel_count), 32'd9);
      chk("a_not_done", 32'(ifa.frame_done), 32'd0);
      step();
      chk("a_done", 32'(ifa.frame_done), 32'd1);
      chk("a_drained", 32'(ifa.word_valid), 32'd0);

      // A: stray pixel after the frame, then clear racing a pixel
      ifa.pix_valid = 1'b1;
      ifa.pix_in    = 9'h055;
      step();
      ifa.pix_valid = 1'b0;
      chk("a_post_ovf", 32'(ifa.overflow), 32'd1);
      chk("a_post_fifo", 32'(ifa.word_valid), 32'd0);
      chk("a_post_done", 32'(ifa.frame_done), 32'd1);
      ifa.clear     = 1'b1;
      ifa.pix_valid = 1'b1;
      ifa.pix_in    = 9'h077;
      step();
      ifa.clear     = 1'b0;
      ifa.pix_valid = 1'b0;
      chk("a_clr_count", 32'(ifa.pixel_count), 32'd0);
      chk("a_clr_ovf", 32'(ifa.overflow), 32'd0);
      chk("a_clr_done", 32'(ifa.frame_done), 32'd0);
      chk("a_clr_valid", 32'(ifa.word_valid), 32'd0);

      // A: clamp word, then reset with one word buffered mid-frame
      ifa.word_ready = 1'b0;
      ifa.pix_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ifa.pix_in = clampv[i];
         step();
      end
      chk("a_clamp", ifa.word_out, 32'h80FF0000);
      ifa.pix_in = 9'h011;
      step();
      ifa.pix_valid = 1'b0;
      chk("a_mid_count", 32'(ifa.pixel_count), 32'd5);
      chk("a_mid_valid", 32'(ifa.word_valid), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("a_rst_valid", 32'(ifa.word_valid), 32'd0);
      chk("a_rst_word", ifa.word_out, 32'h0);
      chk("a_rst_count", 32'(ifa.pixel_count), 32'd0);
      ifa.word_ready = 1'b1;
      ifa.pix_valid  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ifa.pix_in = 9'(8'h21 + k);
         step();
      end
      ifa.pix_valid = 1'b0;
      chk("a_new_lane0", ifa.word_out, 32'h24232221);
      chk("a_new_valid", 32'(ifa.word_valid), 32'd1);

      // B: depth-2 FIFO with no consumer, third word dropped
      ifb.word_ready = 1'b0;
      ifb.pix_valid  = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         ifb.pix_in = 12'(k);
         step();
         if (k == 11) chk("b_no_ovf_yet", 32'(ifb.overflow), 32'd0);
      end
      ifb.pix_valid = 1'b0;
      chk("b_ovf", 32'(ifb.overflow), 32'd1);
      chk("b_head0", ifb.word_out, 32'h04030201);
      chk("b_count12", 32'(ifb.pixel_count), 32'd12);
      ifb.word_ready = 1'b1;
      step();
      chk("b_head1", ifb.word_out, 32'h08070605);
      chk("b_head1_valid", 32'(ifb.word_valid), 32'd1);
      chk("b_not_done", 32'(ifb.frame_done), 32'd0);
      step();
      chk("b_done", 32'(ifb.frame_done), 32'd1);
      chk("b_empty", 32'(ifb.word_valid), 32'd0);
      ifb.word_ready = 1'b0;
      ifb.clear      = 1'b1;
      step();
      ifb.clear = 1'b0;
      chk("b_clr_ovf", 32'(ifb.overflow), 32'd0);

      // B: FIFO held full, pop coincides with the completing push
      ifb.pix_valid = 1'b1;
      for (int k = 0; k < 12; k++) begin
         ifb.pix_in     = (k == 0) ? 12'h7D0 : 12'(k + 1);
         ifb.word_ready = (k == 11);
         step();
         if (k == 7) chk("b_clamp_head", ifb.word_out, 32'h040302FF);
      end
      ifb.pix_valid = 1'b0;
      chk("b_pp_ovf", 32'(ifb.overflow), 32'd0);
      chk("b_pp_head", ifb.word_out, 32'h08070605);
      step();
      chk("b_pp_last", ifb.word_out, 32'h0C0B0A09);
      step();
      chk("b_pp_done", 32'(ifb.frame_done), 32'd1);
      chk("b_pp_ovf_end", 32'(ifb.overflow), 32'd0);
      ifb.word_ready = 1'b0;

      // C: single-pixel frame with a right shift of two
      ifc.word_ready = 1'b1;
      ifc.pix_valid  = 1'b1;
      ifc.pix_in     = 9'h0FF;
      step();
      ifc.pix_valid = 1'b0;
      chk("c_shift", ifc.word_out, 32'h0000003F);
      chk("c_valid", 32'(ifc.word_valid), 32'd1);
      chk("c_count", 32'(ifc.pixel_count), 32'd1);
      chk("c_not_done", 32'(ifc.frame_done), 32'd0);
      step();
      chk("c_done", 32'(ifc.frame_done), 32'd1);
      chk("c_empty", 32'(ifc.word_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
